// File: rtl/apb_gpio_v3_pkg.sv
// Shared definitions for the v3 APB GPIO: register offsets, status field
// positions and the interrupt-type / pad-direction encodings.
package apb_gpio_v3_pkg;

    localparam logic [11:0] OFF_SET     = 12'h000;
    localparam logic [11:0] OFF_CLR     = 12'h004;
    localparam logic [11:0] OFF_TOG     = 12'h008;
    localparam logic [11:0] OFF_PIN     = 12'h010;
    localparam logic [11:0] OFF_OUT     = 12'h020;
    localparam logic [11:0] OFF_SETSEL  = 12'h030;
    localparam logic [11:0] OFF_RDSTAT  = 12'h034;
    localparam logic [11:0] OFF_SETDIR  = 12'h038;
    localparam logic [11:0] OFF_SETINT  = 12'h03C;
    localparam logic [11:0] OFF_INTSTAT = 12'h040;
    localparam logic [11:0] OFF_FILTCFG = 12'h050;

    localparam int RS_DIR     = 24;
    localparam int RS_FILT_EN = 20;
    localparam int RS_INTTYPE = 17;
    localparam int RS_INTEN   = 16;
    localparam int RS_PEND    = 13;
    localparam int RS_IN      = 12;
    localparam int RS_OUT     = 8;
    localparam int FC_THRESH  = 24;

    typedef enum logic [2:0] {
        IT_LEVEL_LOW  = 3'b000,
        IT_FALL       = 3'b001,
        IT_RISE       = 3'b010,
        IT_BOTH       = 3'b011,
        IT_LEVEL_HIGH = 3'b100
    } inttype_e;

    typedef enum logic [1:0] {
        DIR_IN     = 2'b00,
        DIR_PP     = 2'b01,
        DIR_OD     = 2'b10,
        DIR_OD_ALT = 2'b11
    } dir_e;

    // Word-group registers occupy four consecutive words sharing addr[11:4].
    function automatic logic in_group(logic [11:0] addr, logic [11:0] base);
        return (addr[11:4] == base[11:4]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/gpio_v3_pin.sv
// One GPIO input lane: two-flop synchroniser, prescaled glitch filter,
// edge/level event detection and the sticky pending flag.
module gpio_v3_pin
    import apb_gpio_v3_pkg::*;
#(
    parameter int FILT_CNT_W = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  pin_in,
    input  logic                  tick,
    input  logic                  filt_en,
    input  logic [FILT_CNT_W-1:0] thresh,
    input  logic [2:0]            inttype,
    input  logic                  inten,
    input  logic                  w1c,
    output logic                  filtered,
    output logic                  pending
);

    logic                  sync1_reg, sync2_reg, filt_reg, pend_reg;
    logic                  filt_next, evt;
    logic [FILT_CNT_W-1:0] count_reg, count_next;

    always_comb begin
        filt_next  = filt_reg;
        count_next = count_reg;
        if (!filt_en) begin
            filt_next  = sync2_reg;
            count_next = '0;
        end else if (sync2_reg == filt_reg) begin
            count_next = '0;
        end else if (tick) begin
            if (count_reg >= thresh) begin
                filt_next  = sync2_reg;
                count_next = '0;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    // Events look at the value about to be registered so pending rises on
    // the same edge as the filtered output.
    always_comb begin
        case (inttype_e'(inttype))
            IT_LEVEL_LOW:  evt = ~filt_next;
            IT_LEVEL_HIGH: evt = filt_next;
            IT_FALL:       evt = ~filt_next & filt_reg;
            IT_RISE:       evt = filt_next & ~filt_reg;
            IT_BOTH:       evt = filt_next ^ filt_reg;
            default:       evt = 1'b0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            filt_reg  <= 1'b0;
            count_reg <= '0;
            pend_reg  <= 1'b0;
        end else begin
            sync1_reg <= pin_in;
            sync2_reg <= sync1_reg;
            filt_reg  <= filt_next;
            count_reg <= count_next;
            if (evt && inten)
                pend_reg <= 1'b1;
            else if (w1c)
                pend_reg <= 1'b0;
        end
    end

    assign filtered = filt_reg;
    assign pending  = pend_reg;

endmodule

// File: rtl/apb_gpio_v3.sv
// APB GPIO controller: register decode, per-pin configuration, shared filter
// prescaler and pad drive; per-pin input handling lives in gpio_v3_pin.
module apb_gpio_v3
    import apb_gpio_v3_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NGPIO          = 64,
    parameter int FILT_CNT_W     = 4,
    parameter int PRESC_W        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      dft_cg_enable_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NGPIO-1:0]          gpio_in,
    output logic [NGPIO-1:0]          gpio_in_sync,
    output logic [NGPIO-1:0]          gpio_out,
    output logic [NGPIO-1:0]          gpio_dir,
    output logic [NGPIO-1:0]          interrupt,
    output logic                      irq_o
);

    localparam int SELW = (NGPIO > 1) ? $clog2(NGPIO) : 1;
    localparam int NPAD = 128;

    logic [NGPIO-1:0]            out_reg, inten_reg, filt_en_reg, pending;
    logic [NGPIO-1:0][1:0]       dir_reg;
    logic [NGPIO-1:0][2:0]       inttype_reg;
    logic [SELW-1:0]             sel_reg, idx;
    logic [PRESC_W-1:0]          presc_reg, presc_cnt_reg;
    logic [FILT_CNT_W-1:0]       thresh_reg;
    logic [11:0]                 addr;
    logic [1:0]                  grp;
    logic                        wr_en, rd_en, idx_ok, tick;
    logic                        wr_set, wr_clr, wr_tog, wr_sel, wr_dir, wr_int, wr_idx;
    logic                        wr_out, wr_stat, wr_filt;
    logic [NPAD-1:0]             in_pad, out_pad, pend_pad;
    logic [31:0]                 rdstat, filtcfg, rd_data;
    logic                        unused_ok;

    assign addr    = PADDR[11:0];
    assign grp     = addr[3:2];
    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & ~PWRITE;
    assign idx     = PWDATA[SELW-1:0];
    // Range check on a wider field so out-of-range indices never alias.
    assign idx_ok  = ({1'b0, PWDATA[7:0]} < 9'(NGPIO));

    assign wr_set  = wr_en && (addr == OFF_SET);
    assign wr_clr  = wr_en && (addr == OFF_CLR);
    assign wr_tog  = wr_en && (addr == OFF_TOG);
    assign wr_sel  = wr_en && (addr == OFF_SETSEL);
    assign wr_dir  = wr_en && (addr == OFF_SETDIR);
    assign wr_int  = wr_en && (addr == OFF_SETINT);
    assign wr_idx  = wr_set | wr_clr | wr_tog | wr_sel | wr_dir | wr_int;
    assign wr_out  = wr_en && in_group(addr, OFF_OUT);
    assign wr_stat = wr_en && in_group(addr, OFF_INTSTAT);
    assign wr_filt = wr_en && (addr == OFF_FILTCFG);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_reg     <= '0;
            dir_reg     <= '0;
            inttype_reg <= '0;
            inten_reg   <= '0;
            filt_en_reg <= '0;
            sel_reg     <= '0;
            presc_reg   <= '0;
            thresh_reg  <= '0;
        end else begin
            if (idx_ok) begin
                if (wr_set) out_reg[idx] <= 1'b1;
                if (wr_clr) out_reg[idx] <= 1'b0;
                if (wr_tog) out_reg[idx] <= ~out_reg[idx];
                if (wr_dir) dir_reg[idx] <= PWDATA[RS_DIR +: 2];
                if (wr_int) begin
                    inttype_reg[idx] <= PWDATA[RS_INTTYPE +: 3];
                    inten_reg[idx]   <= PWDATA[RS_INTEN];
                    filt_en_reg[idx] <= PWDATA[RS_FILT_EN];
                end
                if (wr_idx) sel_reg <= idx;
            end
            if (wr_out) begin
                for (int i = 0; i < NGPIO; i++)
                    if (grp == 2'(i / 32)) out_reg[i] <= PWDATA[i % 32];
            end
            if (wr_filt) begin
                presc_reg  <= PWDATA[PRESC_W-1:0];
                thresh_reg <= PWDATA[FC_THRESH +: FILT_CNT_W];
            end
        end
    end

    // Free-running prescaler; >= keeps the period sane if presc is lowered mid-count.
    assign tick = (presc_cnt_reg >= presc_reg);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            presc_cnt_reg <= '0;
        else if (tick)
            presc_cnt_reg <= '0;
        else
            presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end

    for (genvar gi = 0; gi < NGPIO; gi++) begin : g_pin
        logic w1c;
        assign w1c = wr_stat && (grp == 2'(gi / 32)) && PWDATA[gi % 32];

        gpio_v3_pin #(.FILT_CNT_W(FILT_CNT_W)) u_pin (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .pin_in   (gpio_in[gi]),
            .tick     (tick),
            .filt_en  (filt_en_reg[gi]),
            .thresh   (thresh_reg),
            .inttype  (inttype_reg[gi]),
            .inten    (inten_reg[gi]),
            .w1c      (w1c),
            .filtered (gpio_in_sync[gi]),
            .pending  (pending[gi])
        );

        // Open-drain pulls low by enabling the driver with a 0 output.
        assign gpio_out[gi]  = (dir_reg[gi] == DIR_PP) & out_reg[gi];
        assign gpio_dir[gi]  = (dir_reg[gi] == DIR_PP) | (dir_reg[gi][1] & ~out_reg[gi]);
        assign interrupt[gi] = pending[gi] & inten_reg[gi];
    end

    assign irq_o    = |interrupt;
    assign in_pad   = NPAD'(gpio_in_sync);
    assign out_pad  = NPAD'(out_reg);
    assign pend_pad = NPAD'(pending);

    always_comb begin
        rdstat                     = '0;
        rdstat[RS_DIR +: 2]        = dir_reg[sel_reg];
        rdstat[RS_FILT_EN]         = filt_en_reg[sel_reg];
        rdstat[RS_INTTYPE +: 3]    = inttype_reg[sel_reg];
        rdstat[RS_INTEN]           = inten_reg[sel_reg];
        rdstat[RS_PEND]            = pending[sel_reg];
        rdstat[RS_IN]              = gpio_in_sync[sel_reg];
        rdstat[RS_OUT]             = out_reg[sel_reg];
        rdstat[SELW-1:0]           = sel_reg;
    end

    assign filtcfg = 32'(presc_reg) | (32'(thresh_reg) << FC_THRESH);

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (in_group(addr, OFF_PIN))
                rd_data = in_pad[{grp, 5'd0} +: 32];
            else if (in_group(addr, OFF_OUT))
                rd_data = out_pad[{grp, 5'd0} +: 32];
            else if (in_group(addr, OFF_INTSTAT))
                rd_data = pend_pad[{grp, 5'd0} +: 32];
            else if (addr == OFF_RDSTAT)
                rd_data = rdstat;
            else if (addr == OFF_FILTCFG)
                rd_data = filtcfg;
        end
    end

    assign PRDATA    = rd_data;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign unused_ok = ^{dft_cg_enable_i, PADDR, PWDATA};

endmodule
